// File: rtl/player_mover_if.sv
// Player update interface between the frame controller, the mover, the
// sin/cos ROM and the map-grid read port.
//   slave  : the mover side (takes the request, drives ROM/grid addresses)
//   master : the environment side (frame controller, ROM and map grid)
// Signals:
//   start, cur_pos_x/y, cur_angle, key_*   request and sampled pose/keys
//   done, next_pos_x/y, next_angle         completion pulse and updated pose
//   trig_angle / trig_cos, trig_sin        ROM address / ROM data (1-cycle latency)
//   grid_x, grid_y / grid_out              grid address / cell contents (1-cycle latency)
interface player_mover_if #(
    parameter int unsigned POS_X_W    = 14,
    parameter int unsigned POS_Y_W    = 13,
    parameter int unsigned ANGLE_W    = 8,
    parameter int unsigned CELL_SHIFT = 8,
    parameter int unsigned TRIG_W     = 8
);
    logic                               start;
    logic                               done;
    logic        [POS_X_W-1:0]          cur_pos_x;
    logic        [POS_Y_W-1:0]          cur_pos_y;
    logic        [ANGLE_W-1:0]          cur_angle;
    logic                               key_fwd;
    logic                               key_back;
    logic                               key_left;
    logic                               key_right;
    logic                               key_strafe_l;
    logic                               key_strafe_r;
    logic        [POS_X_W-1:0]          next_pos_x;
    logic        [POS_Y_W-1:0]          next_pos_y;
    logic        [ANGLE_W-1:0]          next_angle;
    logic        [ANGLE_W-1:0]          trig_angle;
    logic signed [TRIG_W-1:0]           trig_cos;
    logic signed [TRIG_W-1:0]           trig_sin;
    logic        [POS_X_W-CELL_SHIFT-1:0] grid_x;
    logic        [POS_Y_W-CELL_SHIFT-1:0] grid_y;
    logic        [2:0]                  grid_out;

    modport slave (
        input  start, cur_pos_x, cur_pos_y, cur_angle,
        input  key_fwd, key_back, key_left, key_right, key_strafe_l, key_strafe_r,
        input  trig_cos, trig_sin, grid_out,
        output done, next_pos_x, next_pos_y, next_angle,
        output trig_angle, grid_x, grid_y
    );

    modport master (
        output start, cur_pos_x, cur_pos_y, cur_angle,
        output key_fwd, key_back, key_left, key_right, key_strafe_l, key_strafe_r,
        output trig_cos, trig_sin, grid_out,
        input  done, next_pos_x, next_pos_y, next_angle,
        input  trig_angle, grid_x, grid_y
    );
endinterface

// File: rtl/player_mover.sv
// Player pose update: on start, samples pose and keys, turns, then moves
// forward/back and strafes along the new heading, sliding along walls
// (full move, else X-only, else Y-only, else stay).
// Ports:
//   clock  system clock, rising edge
//   reset  asynchronous, active-high
//   bus    player_mover_if.slave (request/pose, ROM port, grid port)
module player_mover #(
    parameter int unsigned POS_X_W    = 14,
    parameter int unsigned POS_Y_W    = 13,
    parameter int unsigned ANGLE_W    = 8,
    parameter int unsigned CELL_SHIFT = 8,
    parameter int unsigned TRIG_W     = 8,
    parameter int unsigned MOVE_STEP  = 16,
    parameter int unsigned TURN_STEP  = 2,
    parameter int unsigned INIT_X     = 0,
    parameter int unsigned INIT_Y     = 0,
    parameter int unsigned INIT_ANGLE = 0
) (
    input logic           clock,
    input logic           reset,
    player_mover_if.slave bus
);
    localparam int unsigned GX_W      = POS_X_W - CELL_SHIFT;
    localparam int unsigned GY_W      = POS_Y_W - CELL_SHIFT;
    // f*cos - s*sin spans +-2^TRIG_W, two guard bits cover it.
    localparam int unsigned SUM_W     = TRIG_W + 2;
    localparam int unsigned PROD_W    = SUM_W + 32;
    localparam int unsigned POS_MAX_W = (POS_X_W > POS_Y_W) ? POS_X_W : POS_Y_W;
    localparam int unsigned CAND_W    = ((PROD_W > POS_MAX_W) ? PROD_W : POS_MAX_W) + 1;
    localparam logic signed [PROD_W-1:0] STEP = PROD_W'(MOVE_STEP);

    typedef enum logic [3:0] {
        StIdle, StAngle, StTrigWait, StCalc, StXyReq, StXyChk,
        StXReq, StXChk, StYReq, StYChk, StDone
    } state_e;

    state_e                     state_q;
    logic        [POS_X_W-1:0]  pos_x_q;
    logic        [POS_Y_W-1:0]  pos_y_q;
    logic        [ANGLE_W-1:0]  angle_q;
    logic signed [1:0]          f_q, s_q;
    logic signed [TRIG_W-1:0]   cos_q, sin_q;
    logic        [POS_X_W-1:0]  cand_x_q;
    logic        [POS_Y_W-1:0]  cand_y_q;
    logic                       cand_x_ok_q, cand_y_ok_q;
    logic                       done_q;
    logic        [POS_X_W-1:0]  next_pos_x_q;
    logic        [POS_Y_W-1:0]  next_pos_y_q;
    logic        [ANGLE_W-1:0]  next_angle_q;
    logic        [ANGLE_W-1:0]  trig_angle_q;
    logic        [GX_W-1:0]     grid_x_q;
    logic        [GY_W-1:0]     grid_y_q;

    logic        [ANGLE_W-1:0]  turned_angle;
    logic signed [SUM_W-1:0]    cos_e, sin_e, sum_x, sum_y;
    logic signed [PROD_W-1:0]   dx, dy;
    logic signed [CAND_W-1:0]   cand_x_w, cand_y_w;
    logic        [POS_X_W-1:0]  cand_x;
    logic        [POS_Y_W-1:0]  cand_y;
    logic                       cand_x_ok, cand_y_ok;
    logic                       cell_free;

    function automatic logic signed [1:0] key_dir(input logic plus, input logic minus);
        case ({plus, minus})
            2'b10:   key_dir = 2'sb01;
            2'b01:   key_dir = 2'sb11;
            default: key_dir = 2'sb00;
        endcase
    endfunction

    function automatic logic signed [SUM_W-1:0] apply_dir(input logic signed [1:0] d,
                                                          input logic signed [SUM_W-1:0] v);
        case (d)
            2'sb01:  apply_dir = v;
            2'sb11:  apply_dir = -v;
            default: apply_dir = '0;
        endcase
    endfunction

    // Scale by MOVE_STEP and drop the trig fraction bits, rounding toward -inf.
    function automatic logic signed [PROD_W-1:0] scale(input logic signed [SUM_W-1:0] sum);
        logic signed [PROD_W-1:0] wide;
        wide  = $signed({{(PROD_W-SUM_W){sum[SUM_W-1]}}, sum});
        scale = (wide * STEP) >>> (TRIG_W - 1);
    endfunction

    always_comb begin
        turned_angle = bus.cur_angle;
        if (bus.key_right && !bus.key_left) begin
            turned_angle = bus.cur_angle + ANGLE_W'(TURN_STEP);
        end else if (bus.key_left && !bus.key_right) begin
            turned_angle = bus.cur_angle - ANGLE_W'(TURN_STEP);
        end
    end

    always_comb begin
        cos_e    = {{2{cos_q[TRIG_W-1]}}, cos_q};
        sin_e    = {{2{sin_q[TRIG_W-1]}}, sin_q};
        sum_x    = apply_dir(f_q, cos_e) - apply_dir(s_q, sin_e);
        sum_y    = apply_dir(f_q, sin_e) + apply_dir(s_q, cos_e);
        dx       = scale(sum_x);
        dy       = scale(sum_y);
        cand_x_w = $signed({{(CAND_W-POS_X_W){1'b0}}, pos_x_q})
                 + $signed({{(CAND_W-PROD_W){dx[PROD_W-1]}}, dx});
        cand_y_w = $signed({{(CAND_W-POS_Y_W){1'b0}}, pos_y_q})
                 + $signed({{(CAND_W-PROD_W){dy[PROD_W-1]}}, dy});
        // In range iff every bit above the position width is zero (not negative, < 2^W).
        cand_x_ok = (cand_x_w[CAND_W-1:POS_X_W] == '0);
        cand_y_ok = (cand_y_w[CAND_W-1:POS_Y_W] == '0);
        cand_x    = cand_x_w[POS_X_W-1:0];
        cand_y    = cand_y_w[POS_Y_W-1:0];
        cell_free = (bus.grid_out == '0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            pos_x_q      <= '0;
            pos_y_q      <= '0;
            angle_q      <= '0;
            f_q          <= '0;
            s_q          <= '0;
            cos_q        <= '0;
            sin_q        <= '0;
            cand_x_q     <= '0;
            cand_y_q     <= '0;
            cand_x_ok_q  <= 1'b0;
            cand_y_ok_q  <= 1'b0;
            done_q       <= 1'b0;
            next_pos_x_q <= POS_X_W'(INIT_X);
            next_pos_y_q <= POS_Y_W'(INIT_Y);
            next_angle_q <= ANGLE_W'(INIT_ANGLE);
            trig_angle_q <= '0;
            grid_x_q     <= '0;
            grid_y_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        pos_x_q      <= bus.cur_pos_x;
                        pos_y_q      <= bus.cur_pos_y;
                        f_q          <= key_dir(bus.key_fwd, bus.key_back);
                        s_q          <= key_dir(bus.key_strafe_r, bus.key_strafe_l);
                        angle_q      <= turned_angle;
                        trig_angle_q <= turned_angle;
                        state_q      <= StAngle;
                    end
                end
                StAngle: begin
                    if (f_q == 2'sb00 && s_q == 2'sb00) begin
                        next_pos_x_q <= pos_x_q;
                        next_pos_y_q <= pos_y_q;
                        next_angle_q <= angle_q;
                        done_q       <= 1'b1;
                        state_q      <= StDone;
                    end else begin
                        state_q <= StTrigWait;
                    end
                end
                StTrigWait: begin
                    cos_q   <= bus.trig_cos;
                    sin_q   <= bus.trig_sin;
                    state_q <= StCalc;
                end
                StCalc: begin
                    cand_x_q    <= cand_x;
                    cand_y_q    <= cand_y;
                    cand_x_ok_q <= cand_x_ok;
                    cand_y_ok_q <= cand_y_ok;
                    grid_x_q    <= cand_x[POS_X_W-1:CELL_SHIFT];
                    grid_y_q    <= cand_y[POS_Y_W-1:CELL_SHIFT];
                    state_q     <= StXyReq;
                end
                StXyReq: state_q <= StXyChk;
                StXyChk: begin
                    if (cell_free && cand_x_ok_q && cand_y_ok_q) begin
                        next_pos_x_q <= cand_x_q;
                        next_pos_y_q <= cand_y_q;
                        next_angle_q <= angle_q;
                        done_q       <= 1'b1;
                        state_q      <= StDone;
                    end else begin
                        grid_x_q <= cand_x_q[POS_X_W-1:CELL_SHIFT];
                        grid_y_q <= pos_y_q[POS_Y_W-1:CELL_SHIFT];
                        state_q  <= StXReq;
                    end
                end
                StXReq: state_q <= StXChk;
                StXChk: begin
                    if (cell_free && cand_x_ok_q) begin
                        next_pos_x_q <= cand_x_q;
                        next_pos_y_q <= pos_y_q;
                        next_angle_q <= angle_q;
                        done_q       <= 1'b1;
                        state_q      <= StDone;
                    end else begin
                        grid_x_q <= pos_x_q[POS_X_W-1:CELL_SHIFT];
                        grid_y_q <= cand_y_q[POS_Y_W-1:CELL_SHIFT];
                        state_q  <= StYReq;
                    end
                end
                StYReq: state_q <= StYChk;
                StYChk: begin
                    next_pos_x_q <= pos_x_q;
                    next_pos_y_q <= (cell_free && cand_y_ok_q) ? cand_y_q : pos_y_q;
                    next_angle_q <= angle_q;
                    done_q       <= 1'b1;
                    state_q      <= StDone;
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.done       = done_q;
    assign bus.next_pos_x = next_pos_x_q;
    assign bus.next_pos_y = next_pos_y_q;
    assign bus.next_angle = next_angle_q;
    assign bus.trig_angle = trig_angle_q;
    assign bus.grid_x     = grid_x_q;
    assign bus.grid_y     = grid_y_q;
endmodule

// File: tb/tb_player_mover.sv
module tb_player_mover;
    localparam logic [5:0] K_FWD   = 6'b100000;
    localparam logic [5:0] K_BACK  = 6'b010000;
    localparam logic [5:0] K_LEFT  = 6'b001000;
    localparam logic [5:0] K_RIGHT = 6'b000100;
    localparam logic [5:0] K_STR_R = 6'b000001;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    player_mover_if #(.POS_X_W(14), .POS_Y_W(13), .ANGLE_W(8), .CELL_SHIFT(8), .TRIG_W(8)) bus ();

    player_mover #(
        .POS_X_W(14), .POS_Y_W(13), .ANGLE_W(8), .CELL_SHIFT(8), .TRIG_W(8),
        .MOVE_STEP(16), .TURN_STEP(2), .INIT_X(0), .INIT_Y(0), .INIT_ANGLE(0)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic signed [7:0] cos_v = 8'sd127;
    logic signed [7:0] sin_v = 8'sd0;
    logic wall [0:63][0:31];

    // ROM and map grid models, both with one cycle of read latency.
    always @(posedge clock) begin
        bus.trig_cos <= cos_v;
        bus.trig_sin <= sin_v;
        bus.grid_out <= wall[bus.grid_x][bus.grid_y] ? 3'd5 : 3'd0;
    end

    int         lat, ndone;
    logic [7:0] ta1;
    logic [5:0] gx4;
    logic [4:0] gy4;

    task automatic drive(input logic [13:0] x, input logic [12:0] y, input logic [7:0] a,
                         input logic [5:0] k);
        bus.cur_pos_x = x;
        bus.cur_pos_y = y;
        bus.cur_angle = a;
        {bus.key_fwd, bus.key_back, bus.key_left, bus.key_right,
         bus.key_strafe_l, bus.key_strafe_r} = k;
    endtask

    // Pulses start, scrambles inputs after C0, optionally re-pulses start at
    // restart_cyc, and watches 16 cycles for done.
    task automatic run_update(input logic [13:0] x, input logic [12:0] y, input logic [7:0] a,
                              input logic [5:0] k, input int restart_cyc);
        lat   = -1;
        ndone = 0;
        @(negedge clock);
        drive(x, y, a, k);
        bus.start = 1'b1;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            @(negedge clock);
            if (cyc == 1) begin
                bus.start = 1'b0;
                drive(14'h2aaa, 13'h1555, 8'h77, 6'b100101);
                ta1 = bus.trig_angle;
            end
            if (cyc == restart_cyc) bus.start = 1'b1;
            else if (cyc == restart_cyc + 1) bus.start = 1'b0;
            if (cyc == 4) begin
                gx4 = bus.grid_x;
                gy4 = bus.grid_y;
            end
            if (bus.done === 1'b1) begin
                ndone++;
                if (lat < 0) lat = cyc;
            end
        end
    endtask

    task automatic test_reset();
        logic [54:0] outs;
        #3 reset = 1'b1;
        #1;
        outs = {bus.done, bus.next_pos_x, bus.next_pos_y, bus.next_angle, bus.trig_angle,
                bus.grid_x, bus.grid_y};
        n_cmp++;
        if (outs !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h want 0", outs);
        end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        ndone = 0;
        repeat (5) begin
            @(negedge clock);
            if (bus.done !== 1'b0) ndone++;
        end
        n_cmp++;
        if (ndone != 0) begin
            n_bad++;
            $display("FAIL reset_idle_done: got %0d done cycles want 0", ndone);
        end
    endtask

    task automatic test_turn();
        cos_v = 8'sd127; sin_v = 8'sd0;
        run_update(14'd1000, 13'd600, 8'd255, K_RIGHT, 0);
        n_cmp++;
        if (lat !== 2 || ndone !== 1) begin
            n_bad++;
            $display("FAIL turn_latency: got lat %0d n %0d want lat 2 n 1", lat, ndone);
        end
        n_cmp++;
        if ({bus.next_pos_x, bus.next_pos_y, bus.next_angle} !== {14'd1000, 13'd600, 8'd1}) begin
            n_bad++;
            $display("FAIL turn_wrap_up: got %0d,%0d,%0d want 1000,600,1",
                     bus.next_pos_x, bus.next_pos_y, bus.next_angle);
        end
        run_update(14'd1000, 13'd600, 8'd40, K_LEFT | K_RIGHT, 0);
        n_cmp++;
        if (lat !== 2 || bus.next_angle !== 8'd40) begin
            n_bad++;
            $display("FAIL turn_both_keys: got lat %0d angle %0d want 2, 40", lat, bus.next_angle);
        end
        run_update(14'd1000, 13'd600, 8'd1, K_LEFT, 0);
        n_cmp++;
        if (lat !== 2 || bus.next_angle !== 8'd255) begin
            n_bad++;
            $display("FAIL turn_wrap_down: got lat %0d angle %0d want 2, 255", lat, bus.next_angle);
        end
    endtask

    task automatic test_forward();
        cos_v = 8'sd127; sin_v = 8'sd0;
        run_update(14'd1000, 13'd600, 8'd0, K_FWD, 0);
        n_cmp++;
        if (ta1 !== 8'd0 || gx4 !== 6'd3 || gy4 !== 5'd2) begin
            n_bad++;
            $display("FAIL fwd_addresses: got trig %0d grid %0d,%0d want 0, 3,2", ta1, gx4, gy4);
        end
        n_cmp++;
        if (lat !== 6 || {bus.next_pos_x, bus.next_pos_y} !== {14'd1015, 13'd600}) begin
            n_bad++;
            $display("FAIL fwd_move: got lat %0d pos %0d,%0d want 6, 1015,600",
                     lat, bus.next_pos_x, bus.next_pos_y);
        end
        run_update(14'd1000, 13'd600, 8'd0, K_STR_R, 0);
        n_cmp++;
        if (lat !== 6 || {bus.next_pos_x, bus.next_pos_y} !== {14'd1000, 13'd615}) begin
            n_bad++;
            $display("FAIL strafe_move: got lat %0d pos %0d,%0d want 6, 1000,615",
                     lat, bus.next_pos_x, bus.next_pos_y);
        end
        // -2032 >>> 7 floors to -16.
        run_update(14'd1000, 13'd600, 8'd0, K_BACK, 0);
        n_cmp++;
        if (lat !== 6 || bus.next_pos_x !== 14'd984) begin
            n_bad++;
            $display("FAIL back_floor: got lat %0d x %0d want 6, 984", lat, bus.next_pos_x);
        end
    endtask

    task automatic test_wall_slide();
        cos_v = 8'sd90; sin_v = 8'sd90;
        run_update(14'd1020, 13'd700, 8'd32, K_FWD, 0);
        n_cmp++;
        if (lat !== 6 || {bus.next_pos_x, bus.next_pos_y, bus.next_angle} !==
            {14'd1031, 13'd711, 8'd32}) begin
            n_bad++;
            $display("FAIL diag_free: got lat %0d pos %0d,%0d want 6, 1031,711",
                     lat, bus.next_pos_x, bus.next_pos_y);
        end
        wall[4][2] = 1'b1;
        run_update(14'd1020, 13'd700, 8'd32, K_FWD, 0);
        n_cmp++;
        if (lat !== 10 || {bus.next_pos_x, bus.next_pos_y} !== {14'd1020, 13'd711}) begin
            n_bad++;
            $display("FAIL slide_y_only: got lat %0d pos %0d,%0d want 10, 1020,711",
                     lat, bus.next_pos_x, bus.next_pos_y);
        end
        wall[3][2] = 1'b1;
        run_update(14'd1020, 13'd700, 8'd32, K_FWD, 0);
        n_cmp++;
        if (lat !== 10 || {bus.next_pos_x, bus.next_pos_y} !== {14'd1020, 13'd700}) begin
            n_bad++;
            $display("FAIL fully_blocked: got lat %0d pos %0d,%0d want 10, 1020,700",
                     lat, bus.next_pos_x, bus.next_pos_y);
        end
        wall[4][2] = 1'b0;
        wall[3][2] = 1'b0;
    endtask

    task automatic test_out_of_range();
        cos_v = -8'sd128; sin_v = 8'sd0;
        run_update(14'd5, 13'd600, 8'd128, K_FWD, 0);
        n_cmp++;
        if (lat !== 10 || {bus.next_pos_x, bus.next_pos_y} !== {14'd5, 13'd600}) begin
            n_bad++;
            $display("FAIL range_fwd_neg: got lat %0d pos %0d,%0d want 10, 5,600",
                     lat, bus.next_pos_x, bus.next_pos_y);
        end
        cos_v = 8'sd127;
        run_update(14'd5, 13'd600, 8'd0, K_BACK, 0);
        n_cmp++;
        if (lat !== 10 || {bus.next_pos_x, bus.next_pos_y} !== {14'd5, 13'd600}) begin
            n_bad++;
            $display("FAIL range_back: got lat %0d pos %0d,%0d want 10, 5,600",
                     lat, bus.next_pos_x, bus.next_pos_y);
        end
    endtask

    task automatic test_restart_ignored();
        cos_v = 8'sd127; sin_v = 8'sd0;
        run_update(14'd1000, 13'd600, 8'd0, K_FWD, 3);
        n_cmp++;
        if (ndone !== 1 || lat !== 6 || bus.next_pos_x !== 14'd1015) begin
            n_bad++;
            $display("FAIL restart_ignored: got n %0d lat %0d x %0d want 1, 6, 1015",
                     ndone, lat, bus.next_pos_x);
        end
    endtask

    task automatic test_reset_mid();
        logic [54:0] outs;
        int          seen;
        seen = 0;
        cos_v = 8'sd127; sin_v = 8'sd0;
        @(negedge clock);
        drive(14'd1000, 13'd600, 8'd10, K_FWD);
        bus.start = 1'b1;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge clock);
            bus.start = 1'b0;
            if (bus.done === 1'b1) seen++;
        end
        #2 reset = 1'b1;
        #1;
        outs = {bus.done, bus.next_pos_x, bus.next_pos_y, bus.next_angle, bus.trig_angle,
                bus.grid_x, bus.grid_y};
        n_cmp++;
        if (outs !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_outputs: got %h want 0", outs);
        end
        @(negedge clock);
        reset = 1'b0;
        repeat (12) begin
            @(negedge clock);
            if (bus.done === 1'b1) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL reset_mid_no_done: got %0d done cycles want 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clock);
        drive(14'd200, 13'd300, 8'd10, K_RIGHT);
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        @(negedge clock);
        n_cmp++;
        if (bus.done !== 1'b1 || bus.next_angle !== 8'd12) begin
            n_bad++;
            $display("FAIL b2b_first: got done %b angle %0d want 1, 12", bus.done, bus.next_angle);
        end
        @(negedge clock);
        n_cmp++;
        if (bus.done !== 1'b0 || bus.next_angle !== 8'd12) begin
            n_bad++;
            $display("FAIL b2b_hold: got done %b angle %0d want 0, 12", bus.done, bus.next_angle);
        end
        drive(14'd200, 13'd300, 8'd100, K_LEFT);
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        @(negedge clock);
        n_cmp++;
        if (bus.done !== 1'b1 || bus.next_angle !== 8'd98) begin
            n_bad++;
            $display("FAIL b2b_second: got done %b angle %0d want 1, 98", bus.done, bus.next_angle);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 64; i++) begin
            for (int j = 0; j < 32; j++) wall[i][j] = 1'b0;
        end
        bus.start = 1'b0;
        drive(14'd0, 13'd0, 8'd0, 6'b000000);
        test_reset();
        test_turn();
        test_forward();
        test_wall_slide();
        test_out_of_range();
        test_restart_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
